// File: rtl/conv_acc_pkg.sv
// ============================================================================
//  Module      : conv_acc_pkg
//  Description : Shared types, constants and count helpers for the pooling
//                I/O controller, plus the SRAM write-request encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WRITE_ENB
`define WRITE_ENB 1'b1
`endif
`ifndef WRITE_DIS
`define WRITE_DIS 1'b0
`endif

package conv_acc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PARAM = 3'd1,
        ST_INPUT = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } pool_state_t;

    localparam int unsigned DATA_W                = 32;
    localparam int unsigned COUNT_W               = 20;
    localparam int unsigned PARAM_WORDS           = 4;
    localparam int unsigned PARAM_IDX_NUM_ROW     = 0;
    localparam int unsigned PARAM_IDX_NUM_CHANNEL = 1;
    localparam int unsigned PARAM_IDX_RESERVED    = 2;
    localparam int unsigned PARAM_IDX_KERNEL      = 3;
    localparam int unsigned DEFAULT_OUT_COUNT     = 20;

    function automatic logic [COUNT_W-1:0] calc_in_count(
        input logic [5:0] num_row,
        input logic [7:0] num_channel
    );
        logic [11:0] w_sq;
        w_sq = 12'(num_row) * 12'(num_row);
        return COUNT_W'(w_sq) * COUNT_W'(num_channel);
    endfunction

    // Only a 2x2 kernel shrinks the map; every other kernel drains a fixed block.
    function automatic logic [COUNT_W-1:0] calc_out_count(
        input logic [5:0]  num_row,
        input logic [7:0]  num_channel,
        input logic [31:0] kernel_size
    );
        logic [11:0] w_sq;
        w_sq = 12'(num_row) * 12'(num_row);
        if (kernel_size == 32'd2)
            return COUNT_W'(w_sq >> 2) * COUNT_W'(num_channel);
        else
            return COUNT_W'(DEFAULT_OUT_COUNT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sp_ram_intf.sv
// ============================================================================
//  Module      : sp_ram_intf
//  Description : Single-port SRAM access bundle; read data is valid one
//                cycle after cs+addr.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sp_ram_intf;
    logic        cs;
    logic        oe;
    logic        W_req;
    logic [31:0] addr;
    logic [31:0] W_data;
    logic [31:0] R_data;

    modport compute (output cs, oe, W_req, addr, W_data, input R_data);
    modport memory  (input cs, oe, W_req, addr, W_data, output R_data);
endinterface

`default_nettype wire

// File: rtl/rd_skid_fifo.sv
// ============================================================================
//  Module      : rd_skid_fifo
//  Description : Two-entry FIFO catching SRAM read returns while the host
//                read stream is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_skid_fifo #(
    parameter int WIDTH = 32
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              push,
    input  wire  [WIDTH-1:0] push_data,
    input  wire              pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push   = push && (r_count != 2'd2);
    assign w_pop    = pop  && (r_count != 2'd0);
    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pool_io_ctrl.sv
// ============================================================================
//  Module      : pool_io_ctrl
//  Description : Loads parameters and input map into SRAM, kicks the pooling
//                engine, then streams the output SRAM back to the host.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_io_ctrl
    import conv_acc_pkg::*;
(
    input  wire         clk,
    input  wire         rst,
    input  wire         cmd_start,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic        cmd_err,
    input  wire         in_valid,
    output logic        in_ready,
    input  wire  [31:0] in_data,
    input  wire         in_last,
    output logic        out_valid,
    input  wire         out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        eng_start,
    input  wire         eng_finish,
    output logic        mem_own,
    sp_ram_intf.compute param_intf,
    sp_ram_intf.compute input_intf,
    sp_ram_intf.compute output_intf
);

    localparam logic [COUNT_W-1:0] c_param_last = COUNT_W'(PARAM_WORDS - 1);
    localparam logic [COUNT_W-1:0] c_one        = COUNT_W'(1);

    pool_state_t        r_state;
    pool_state_t        w_state_nxt;
    logic [COUNT_W-1:0] r_cnt;
    logic [COUNT_W-1:0] r_rd_cnt;
    logic [COUNT_W-1:0] r_pop_cnt;
    logic [5:0]         r_num_row;
    logic [7:0]         r_num_channel;
    logic [31:0]        r_kernel_size;
    logic               r_err;
    logic               r_rd_pending;
    logic [COUNT_W-1:0] w_in_count;
    logic [COUNT_W-1:0] w_out_count;
    logic               w_accept;
    logic               w_is_final;
    logic               w_rd_issue;
    logic               w_pop;
    logic [1:0]         w_fifo_count;
    logic [31:0]        w_fifo_data;
    logic               w_param_wr;
    logic               w_input_wr;
    logic               w_unused;

    assign w_in_count  = calc_in_count(r_num_row, r_num_channel);
    assign w_out_count = calc_out_count(r_num_row, r_num_channel, r_kernel_size);

    assign in_ready   = (r_state == ST_PARAM) || (r_state == ST_INPUT);
    assign w_accept   = in_ready && in_valid;
    assign w_param_wr = w_accept && (r_state == ST_PARAM);
    assign w_input_wr = w_accept && (r_state == ST_INPUT);

    // The final host word is the last INPUT word, or PARAM word 3 when there is no input.
    always_comb begin
        w_is_final = 1'b0;
        if (r_state == ST_PARAM)
            w_is_final = (r_cnt == c_param_last) && (w_in_count == '0);
        else if (r_state == ST_INPUT)
            w_is_final = (r_cnt == w_in_count - c_one);
    end

    // Returns in flight count against FIFO space so a push never finds it full.
    assign w_rd_issue = (r_state == ST_DRAIN) && (r_rd_cnt < w_out_count) &&
                        ((w_fifo_count + {1'b0, r_rd_pending}) < 2'd2);
    assign out_valid  = (w_fifo_count != 2'd0);
    assign w_pop      = out_valid && out_ready;
    assign out_last   = out_valid && (r_pop_cnt == w_out_count - c_one);
    assign out_data   = w_fifo_data;

    assign cmd_busy  = (r_state != ST_IDLE);
    assign cmd_done  = (r_state == ST_DONE);
    assign cmd_err   = r_err;
    assign eng_start = (r_state == ST_START);
    assign mem_own   = !((r_state == ST_START) || (r_state == ST_WAIT));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (cmd_start) w_state_nxt = ST_PARAM;
            ST_PARAM: if (w_accept && (r_cnt == c_param_last))
                          w_state_nxt = (w_in_count == '0) ? ST_START : ST_INPUT;
            ST_INPUT: if (w_accept && w_is_final) w_state_nxt = ST_START;
            ST_START: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (eng_finish) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if ((w_out_count == '0) || (w_pop && out_last))
                          w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_rd_cnt      <= '0;
            r_pop_cnt     <= '0;
            r_num_row     <= '0;
            r_num_channel <= '0;
            r_kernel_size <= '0;
            r_err         <= 1'b0;
            r_rd_pending  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_pending <= w_rd_issue;

            if (r_state != w_state_nxt)
                r_cnt <= '0;
            else if (w_accept)
                r_cnt <= r_cnt + c_one;

            if (r_state == ST_IDLE) begin
                r_rd_cnt  <= '0;
                r_pop_cnt <= '0;
            end else begin
                if (w_rd_issue) r_rd_cnt  <= r_rd_cnt + c_one;
                if (w_pop)      r_pop_cnt <= r_pop_cnt + c_one;
            end

            if (w_param_wr) begin
                if (r_cnt == COUNT_W'(PARAM_IDX_NUM_ROW))     r_num_row     <= in_data[5:0];
                if (r_cnt == COUNT_W'(PARAM_IDX_NUM_CHANNEL)) r_num_channel <= in_data[7:0];
                if (r_cnt == COUNT_W'(PARAM_IDX_KERNEL))      r_kernel_size <= in_data;
            end

            if ((r_state == ST_IDLE) && cmd_start)
                r_err <= 1'b0;
            else if (w_accept && (in_last != w_is_final))
                r_err <= 1'b1;
        end
    end

    rd_skid_fifo #(.WIDTH(DATA_W)) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_rd_pending),
        .push_data (output_intf.R_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_data),
        .count     (w_fifo_count)
    );

    assign param_intf.cs     = w_param_wr;
    assign param_intf.oe     = 1'b1;
    assign param_intf.W_req  = w_param_wr ? `WRITE_ENB : `WRITE_DIS;
    assign param_intf.addr   = w_param_wr ? 32'(r_cnt) : 32'd0;
    assign param_intf.W_data = w_param_wr ? in_data : 32'd0;

    assign input_intf.cs     = w_input_wr;
    assign input_intf.oe     = 1'b1;
    assign input_intf.W_req  = w_input_wr ? `WRITE_ENB : `WRITE_DIS;
    assign input_intf.addr   = w_input_wr ? 32'(r_cnt) : 32'd0;
    assign input_intf.W_data = w_input_wr ? in_data : 32'd0;

    assign output_intf.cs     = w_rd_issue;
    assign output_intf.oe     = 1'b1;
    assign output_intf.W_req  = `WRITE_DIS;
    assign output_intf.addr   = w_rd_issue ? 32'(r_rd_cnt) : 32'd0;
    assign output_intf.W_data = 32'd0;

    assign w_unused = ^{param_intf.R_data, input_intf.R_data};

endmodule

`default_nettype wire

// File: tb/tb_pool_io_ctrl.sv
// ============================================================================
//  Module      : tb_pool_io_ctrl
//  Description : Self-checking bench for pool_io_ctrl with SRAM models, an
//                engine stub and write/read scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pool_io_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_busy, cmd_done, cmd_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic        eng_start;
    logic        eng_finish = 1'b0;
    logic        mem_own;

    sp_ram_intf param_intf ();
    sp_ram_intf input_intf ();
    sp_ram_intf output_intf ();

    pool_io_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_start   (cmd_start),
        .cmd_busy    (cmd_busy),
        .cmd_done    (cmd_done),
        .cmd_err     (cmd_err),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .eng_start   (eng_start),
        .eng_finish  (eng_finish),
        .mem_own     (mem_own),
        .param_intf  (param_intf),
        .input_intf  (input_intf),
        .output_intf (output_intf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nr; int nc; int k; int last_pos; int mode; int delay;
        int exp_in; int exp_out; int exp_err;
    } vec_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [31:0] data; logic last; } rd_t;

    vec_t vecs [0:8];
    wr_t  par_q[$];
    wr_t  in_q[$];
    rd_t  out_q[$];

    logic [31:0] par_mem [0:3];
    logic [31:0] in_mem  [0:63];
    logic [31:0] out_mem [0:63];
    logic [31:0] out_rdata = '0;

    int n_vec = 0, n_bad = 0, cyc = 0;
    int n_in_wr, n_par_wr, n_eng, n_pop, iss, pops, max_out;
    int last_cyc, done_cyc, rdy_mode = 0, prev_err = 0;
    logic eng_own_bad;

    assign param_intf.R_data  = '0;
    assign input_intf.R_data  = '0;
    assign output_intf.R_data = out_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input int act, input int exp);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // SRAM models: writes land on the edge, reads return one cycle later.
    always @(posedge clk) begin
        if (param_intf.cs && param_intf.W_req == `WRITE_ENB && param_intf.addr < 32'd4)
            par_mem[param_intf.addr[1:0]] <= param_intf.W_data;
        if (input_intf.cs && input_intf.W_req == `WRITE_ENB && input_intf.addr < 32'd64)
            in_mem[input_intf.addr[5:0]] <= input_intf.W_data;
        if (output_intf.cs && output_intf.W_req == `WRITE_DIS)
            out_rdata <= out_mem[output_intf.addr[5:0]];
    end

    // Scoreboard side: compare everything the DUT commits on the coming edge.
    always @(negedge clk) begin : mon
        wr_t e;
        rd_t r;
        cyc = cyc + 1;
        if (!rst) begin
            if (param_intf.cs && param_intf.W_req == `WRITE_ENB) begin
                n_par_wr++;
                if (par_q.size() == 0) note_fail("param_extra_write", int'(param_intf.addr), -1);
                else begin
                    e = par_q.pop_front();
                    chk("param_addr", param_intf.addr, e.addr);
                    chk("param_data", param_intf.W_data, e.data);
                end
            end
            if (input_intf.cs && input_intf.W_req == `WRITE_ENB) begin
                n_in_wr++;
                if (in_q.size() == 0) note_fail("input_extra_write", int'(input_intf.addr), -1);
                else begin
                    e = in_q.pop_front();
                    chk("input_addr", input_intf.addr, e.addr);
                    chk("input_data", input_intf.W_data, e.data);
                end
            end
            if (output_intf.cs) iss++;
            if (eng_start) begin
                n_eng++;
                if (mem_own) eng_own_bad = 1'b1;
            end
            if (out_valid && out_ready) begin
                pops++;
                n_pop++;
                if (out_q.size() == 0) note_fail("out_extra_word", int'(out_data), -1);
                else begin
                    r = out_q.pop_front();
                    chk("out_data", out_data, r.data);
                    chk("out_last", 32'(out_last), 32'(r.last));
                    if (r.last) last_cyc = cyc;
                end
            end
            if ((iss - pops) > max_out) max_out = iss - pops;
            if (cmd_done) done_cyc = cyc;
        end
    end

    // Host read-side back-pressure: always ready, or 1-0-0-1 followed by random.
    initial begin : rdy_gen
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_ready = 1'b1;
            else begin
                case (ph % 8)
                    0, 3:    out_ready = 1'b1;
                    1, 2:    out_ready = 1'b0;
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                ph++;
            end
        end
    end

    task automatic send_word(input logic [31:0] data, input logic last);
        logic acc;
        int t;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        t = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 100);
        if (!acc) note_fail("in_ready_timeout", 0, 1);
    endtask

    task automatic run_job(input int idx, input int abort_after);
        vec_t        v;
        logic [31:0] w [0:3];
        logic        last;
        int          t;
        v = vecs[idx];
        n_in_wr = 0; n_par_wr = 0; n_eng = 0; n_pop = 0;
        iss = 0; pops = 0; max_out = 0; eng_own_bad = 1'b0;
        last_cyc = 0; done_cyc = 0;
        rdy_mode = v.mode;

        @(negedge clk);
        chk($sformatf("v%0d_err_sticky", idx), 32'(cmd_err), 32'(prev_err));
        @(posedge clk); #1 cmd_start = 1'b1;
        @(posedge clk); #1 cmd_start = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_busy", idx), 32'(cmd_busy), 32'd1);
        chk($sformatf("v%0d_err_clear", idx), 32'(cmd_err), 32'd0);
        @(posedge clk); #1;

        w[0] = 32'hABCD_EF00 | 32'(v.nr);
        w[1] = 32'h1234_5600 | 32'(v.nc);
        w[2] = 32'h5EED_0000 + 32'(idx);
        w[3] = 32'(v.k);
        for (int i = 0; i < 4; i++) begin
            par_q.push_back('{addr: 32'(i), data: w[i]});
            send_word(w[i], (v.exp_in == 0) && (i == 3));
        end
        for (int k = 0; k < v.exp_in; k++) begin
            last = (v.last_pos >= 0) ? (k == v.last_pos) : (k == v.exp_in - 1);
            in_q.push_back('{addr: 32'(k), data: 32'h1000_0000 + 32'(idx << 16) + 32'(k)});
            send_word(32'h1000_0000 + 32'(idx << 16) + 32'(k), last);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        t = 0;
        while (n_eng == 0 && t < 200) begin @(negedge clk); t++; end
        if (n_eng == 0) note_fail($sformatf("v%0d_eng_start_timeout", idx), 0, 1);

        repeat (v.delay) @(posedge clk);
        #1;
        for (int i = 0; i < v.exp_out; i++)
            out_q.push_back('{data: out_mem[i], last: (i == v.exp_out - 1)});
        eng_finish = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!mem_own && t < 100);
        if (!mem_own) note_fail($sformatf("v%0d_drain_timeout", idx), 0, 1);
        @(posedge clk); #1 eng_finish = 1'b0;

        t = 0;
        forever begin
            @(negedge clk);
            t++;
            if (cmd_done || t >= 3000) break;
            if (abort_after > 0 && n_pop >= abort_after) break;
        end

        if (abort_after > 0) begin
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            @(negedge clk);
            chk("rst_drain_out_valid", 32'(out_valid), 32'd0);
            chk("rst_drain_busy", 32'(cmd_busy), 32'd0);
            chk("rst_drain_in_ready", 32'(in_ready), 32'd0);
            chk("rst_drain_mem_own", 32'(mem_own), 32'd1);
            chk("rst_drain_err", 32'(cmd_err), 32'd0);
            out_q.delete();
            prev_err = 0;
            return;
        end

        if (!cmd_done) note_fail($sformatf("v%0d_done_timeout", idx), 0, 1);
        chk($sformatf("v%0d_cmd_err", idx), 32'(cmd_err), 32'(v.exp_err));
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", idx), 32'(cmd_done), 32'd0);
        chk($sformatf("v%0d_idle", idx), 32'(cmd_busy), 32'd0);
        if (v.exp_out > 0)
            chk($sformatf("v%0d_done_latency", idx), 32'(done_cyc - last_cyc), 32'd1);
        chk($sformatf("v%0d_eng_pulses", idx), 32'(n_eng), 32'd1);
        chk($sformatf("v%0d_eng_mem_own", idx), 32'(eng_own_bad), 32'd0);
        chk($sformatf("v%0d_param_writes", idx), 32'(n_par_wr), 32'd4);
        chk($sformatf("v%0d_input_writes", idx), 32'(n_in_wr), 32'(v.exp_in));
        chk($sformatf("v%0d_out_words", idx), 32'(n_pop), 32'(v.exp_out));
        chk($sformatf("v%0d_out_q_empty", idx), 32'(out_q.size()), 32'd0);
        chk($sformatf("v%0d_outstanding_le2", idx), 32'(max_out <= 2), 32'd1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("v%0d_par_mem%0d", idx, i), par_mem[i], w[i]);
        prev_err = v.exp_err;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d miscompares so far", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        //           nr nc k  last mode dly  in  out err
        vecs[0] = '{4, 2, 2, -1, 0, 50, 32,  8, 0};
        vecs[1] = '{4, 2, 2, -1, 1,  5, 32,  8, 0};
        vecs[2] = '{4, 2, 2,  9, 0,  3, 32,  8, 1};
        vecs[3] = '{4, 2, 3, -1, 1,  4, 32, 20, 0};
        vecs[4] = '{3, 0, 1, -1, 1,  2,  0, 20, 0};
        vecs[5] = '{3, 0, 2, -1, 0,  2,  0,  0, 0};
        vecs[6] = '{5, 1, 2, -1, 1,  7, 25,  6, 0};
        vecs[7] = '{2, 3, 2, -1, 1,  1, 12,  3, 0};
        vecs[8] = '{6, 1, 2, -1, 0, 10, 36,  9, 0};
        for (int i = 0; i < 64; i++)
            out_mem[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0013);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy_done_err", {29'd0, cmd_busy, cmd_done, cmd_err}, 32'd0);
        chk("rst_eng_start", 32'(eng_start), 32'd0);
        chk("rst_mem_own", 32'(mem_own), 32'd1);
        chk("rst_cs", {29'd0, param_intf.cs, input_intf.cs, output_intf.cs}, 32'd0);
        chk("rst_wreq", {29'd0, param_intf.W_req, input_intf.W_req, output_intf.W_req},
            {29'd0, `WRITE_DIS, `WRITE_DIS, `WRITE_DIS});
        chk("rst_addr", param_intf.addr | input_intf.addr | output_intf.addr, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_job(i, 0);

        run_job(0, 3);
        run_job(0, 0);
        run_job(6, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pool_io_ctrl.md
POOL_IO_CTRL -- requirements
Module: pool_io_ctrl

Interface
REQ-001 SHALL have: clk  input  1  sole clock, all logic on posedge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: cmd_start  input  1  begin one load/run/drain job; cmd_busy  output  1  job in progress; cmd_done  output  1  one-cycle job-complete pulse; cmd_err  output  1  sticky in_last mismatch flag.
REQ-004 SHALL have: in_valid  input  1; in_ready  output  1; in_data  input  32; in_last  input  1  host write stream.
REQ-005 SHALL have: out_valid  output  1; out_ready  input  1; out_data  output  32; out_last  output  1  host read stream.
REQ-006 SHALL have: eng_start  output  1  one-cycle pulse to pooling engine; eng_finish  input  1  engine complete level; mem_own  output  1  high while this block drives the three SRAMs (top-level mux select).
REQ-007 SHALL have: param_intf, input_intf, output_intf  sp_ram_intf.compute ports (cs, oe, W_req, addr 32, W_data 32, R_data 32); W_req uses `WRITE_ENB/`WRITE_DIS; read data valid one cycle after cs+addr.

Function
REQ-008 SHALL implement states IDLE, PARAM, INPUT, START, WAIT, DRAIN, DONE.
REQ-009 IDLE->PARAM on cmd_start; cmd_start ignored in every other state.
REQ-010 PARAM: accept exactly 4 words (in_valid&&in_ready), write param SRAM addr 0..3, W_req=`WRITE_ENB only on accepted cycles; capture word0[5:0]=num_row, word1[7:0]=num_channel, word3=kernel_size; word2 reserved, written unchanged.
REQ-011 INPUT: in_count = num_row*num_row*num_channel (20-bit unsigned); accept words to input SRAM addr 0..in_count-1 sequentially; in_count==0 -> go directly to START.
REQ-012 in_last SHALL be checked only on the final accepted word of INPUT (or of PARAM if in_count==0): deasserted there, or asserted on any earlier word, sets cmd_err; transfer length always follows the counts, never in_last.
REQ-013 in_ready SHALL be 1 only in PARAM and INPUT; zero-bubble, one word per cycle.
REQ-014 START: eng_start=1 for exactly one cycle, mem_own=0 from START through WAIT; WAIT->DRAIN on first cycle eng_finish=1.
REQ-015 DRAIN: out_count = ((num_row*num_row)>>2)*num_channel if kernel_size==2, else 20; read output SRAM addr 0..out_count-1, presenting each word on out_data in address order.
REQ-016 DRAIN SHALL use a 2-entry read FIFO; a read is issued only if FIFO occupancy plus in-flight reads < 2; out_valid = FIFO non-empty; pop on out_valid&&out_ready; no word lost or duplicated under any out_ready pattern.
REQ-017 out_last SHALL be 1 with the final word only; out_count==0 -> DRAIN->DONE immediately, no out_valid.
REQ-018 DONE: cmd_done=1 one cycle, then IDLE; cmd_busy=1 in all states except IDLE.
REQ-019 All SRAM cs/W_req deasserted outside PARAM, INPUT, DRAIN; oe=1 constant; unused port fields driven 0 / `WRITE_DIS.
REQ-020 cmd_err SHALL clear only on cmd_start accepted in IDLE.

Reset
REQ-021 rst SHALL force IDLE, clear all counters, captured parameters, FIFO and in-flight tracking, from any state including mid-DRAIN.
REQ-022 Reset values: in_ready=0, out_valid=0, out_last=0, out_data=0, cmd_busy=0, cmd_done=0, cmd_err=0, eng_start=0, mem_own=1, all cs=0, W_req=`WRITE_DIS, addr=0.

Structure
REQ-023 State enum, PARAM_WORDS=4, parameter word indices, and the default out_count 20 SHALL live in shared package conv_acc_pkg alongside ConvAcc.svh macros.
REQ-024 The read FIFO SHALL be sub-module rd_skid_fifo (depth 2, 32-bit); remaining logic flat.

Verification
REQ-025 num_row=4, num_channel=2, kernel=2, 32 input words, in_last on word 32 -> param SRAM {4,2,x,2}, input SRAM 0..31 exact, one eng_start, cmd_err=0.
REQ-026 Same job, engine finishes after 50 cycles, out_ready=1 -> 8 words addr 0..7 in order, out_last on word 8, cmd_done one cycle later.
REQ-027 out_ready toggling 1-0-0-1 random -> identical 8-word sequence, no drop/duplicate, ≤2 reads outstanding.
REQ-028 in_last on word 10 of 32 -> cmd_err=1, all 32 words still written, job completes; next cmd_start clears cmd_err.
REQ-029 kernel_size=3 -> exactly 20 output words; num_channel=0 -> no input writes, eng_start still pulses, out_count 20.
REQ-030 rst asserted mid-DRAIN after 3 words -> next cycle IDLE, out_valid=0, cmd_busy=0; fresh job runs correctly.
